// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths,
// memory-operation codes, FSM states and operation classification helpers.
package mem_stage_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 4;

    typedef enum logic [MEM_OP_W-1:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_load(logic [MEM_OP_W-1:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic is_store(logic [MEM_OP_W-1:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of four.
    function automatic logic misaligned(logic [MEM_OP_W-1:0] op, logic [1:0] lane);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lane[0];
            OP_LW, OP_SW:         return lane != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of a RAM
// word and sign- or zero-extends it according to the load type.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op,
    input  logic [1:0]          addr,
    input  logic [REG_W-1:0]    rdata,
    output logic [REG_W-1:0]    value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (op)
            OP_LB:   value = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  value = {24'd0, byte_lane};
            OP_LH:   value = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  value = {16'd0, half_lane};
            OP_LW:   value = rdata;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: turns EX/MEM load/store requests into a registered
// req/ack RAM transaction, stalling the front of the pipe until it completes.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] mem_reg_waddr,
    input  logic                  mem_we,
    input  logic [REG_W-1:0]      mem_reg_wdata,
    input  logic [MEM_OP_W-1:0]   mem_op,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_sdata,
    output logic                  ram_req,
    output logic                  ram_wr,
    output logic [31:0]           ram_addr,
    output logic [31:0]           ram_wdata,
    output logic [3:0]            ram_wmask,
    input  logic                  ram_ack,
    input  logic [31:0]           ram_rdata,
    output logic [REG_ADDR_W-1:0] wb_reg_waddr,
    output logic                  wb_we,
    output logic [REG_W-1:0]      wb_reg_wdata,
    output logic                  stall_req,
    output logic                  misalign
);

    state_e                state;
    logic [MEM_OP_W-1:0]   cap_op;
    logic [1:0]            cap_lane;
    logic [REG_ADDR_W-1:0] cap_waddr;
    logic                  cap_we;
    logic [REG_W-1:0]      cap_wdata;
    logic [REG_W-1:0]      result;
    logic [REG_W-1:0]      load_value;
    logic                  op_mem;
    logic                  op_bad;

    function automatic logic [31:0] store_data(logic [MEM_OP_W-1:0] op, logic [31:0] sdata);
        case (op)
            OP_SB:   return {4{sdata[7:0]}};
            OP_SH:   return {2{sdata[15:0]}};
            OP_SW:   return sdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(logic [MEM_OP_W-1:0] op, logic [1:0] lane);
        case (op)
            OP_SB:   return 4'b0001 << lane;
            OP_SH:   return 4'b0011 << lane;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    load_align u_load_align (
        .op    (cap_op),
        .addr  (cap_lane),
        .rdata (ram_rdata),
        .value (load_value)
    );

    always_comb begin
        op_mem       = is_load(mem_op) || is_store(mem_op);
        op_bad       = op_mem && misaligned(mem_op, mem_addr[1:0]);
        stall_req    = 1'b0;
        wb_reg_waddr = mem_reg_waddr;
        wb_we        = mem_we;
        wb_reg_wdata = mem_reg_wdata;
        case (state)
            S_IDLE: begin
                // Memory ops write back only from DONE; a faulting op never does.
                if (op_mem) begin
                    wb_we     = 1'b0;
                    stall_req = !op_bad;
                end
            end
            S_BUSY: begin
                wb_we     = 1'b0;
                stall_req = 1'b1;
            end
            S_DONE: begin
                wb_reg_waddr = cap_waddr;
                wb_we        = cap_we;
                wb_reg_wdata = is_load(cap_op) ? result : cap_wdata;
            end
            default: ;
        endcase
        if (rst) begin
            stall_req = 1'b0;
            wb_we     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ram_req   <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wmask <= '0;
            misalign  <= 1'b0;
            cap_op    <= '0;
            cap_lane  <= '0;
            cap_waddr <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            result    <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_bad) begin
                        misalign <= 1'b1;
                    end else if (op_mem) begin
                        cap_op    <= mem_op;
                        cap_lane  <= mem_addr[1:0];
                        cap_waddr <= mem_reg_waddr;
                        cap_we    <= mem_we;
                        cap_wdata <= mem_reg_wdata;
                        ram_req   <= 1'b1;
                        ram_wr    <= is_store(mem_op);
                        ram_addr  <= {mem_addr[31:2], 2'b00};
                        ram_wdata <= store_data(mem_op, mem_sdata);
                        ram_wmask <= store_mask(mem_op, mem_addr[1:0]);
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ram_ack) begin
                        result  <= load_value;
                        ram_req <= 1'b0;
                        ram_wr  <= 1'b0;
                        state   <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; single clock, all state on posedge clk.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have inputs from EX/MEM register: mem_reg_waddr in 5 (`RegAddrBus), mem_we in 1, mem_reg_wdata in 32 (`RegBus), mem_op in 4 (`MemOpBus), mem_addr in 32, mem_sdata in 32.
REQ-004 SHALL have RAM port: ram_req out 1, ram_wr out 1, ram_addr out 32 (word-aligned, bits[1:0]=0), ram_wdata out 32, ram_wmask out 4, ram_ack in 1, ram_rdata in 32.
REQ-005 SHALL have outputs to MEM/WB register: wb_reg_waddr out 5, wb_we out 1, wb_reg_wdata out 32.
REQ-006 SHALL have outputs stall_req out 1 (freeze PC..EX/MEM) and misalign out 1 (one-cycle error pulse).

Function
REQ-007 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-008 mem_op encoding SHALL be NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9-15 SHALL be treated as NONE.
REQ-009 IDLE with NONE: wb_* SHALL equal mem_* combinationally; stall_req=0; no RAM request.
REQ-010 IDLE with aligned load/store: stall_req=1 combinationally; SHALL capture op, addr, sdata, waddr, we; next state BUSY.
REQ-011 Alignment: halfword SHALL require addr[0]=0, word addr[1:0]=0; violation in IDLE SHALL pulse misalign=1 (registered, next cycle), force wb_we=0 that cycle, no RAM request, stay IDLE, stall_req=0.
REQ-012 BUSY: ram_req=1 with ram_addr/ram_wr/ram_wdata/ram_wmask held stable (registered) until ram_ack sampled high; stall_req=1.
REQ-013 Store: ram_wr=1; ram_wdata SHALL replicate byte (x4) for SB, halfword (x2) for SH, full for SW; ram_wmask SHALL be 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), 1111 (SW).
REQ-014 Load: ram_wr=0, ram_wmask=0000; on ack SHALL select byte/half lane by addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU, and register the result.
REQ-015 BUSY with ram_ack=1 SHALL transition to DONE; ram_req SHALL be 0 in the DONE cycle.
REQ-016 DONE: stall_req=0; wb_reg_waddr/wb_we SHALL be the captured values; wb_reg_wdata SHALL be the load result (loads) or captured mem_reg_wdata (stores); next state IDLE unconditionally.
REQ-017 Minimum memory-op latency SHALL be 3 cycles (IDLE, BUSY with immediate ack, DONE); each extra ack-wait cycle adds one.
REQ-018 ram_ack outside BUSY SHALL be ignored.
REQ-019 wb_we SHALL be 0 in IDLE-start and BUSY cycles of a memory op (no duplicate writeback).

Reset
REQ-020 rst=1 at any posedge SHALL force state IDLE, ram_req=0, ram_wr=0, ram_addr=0, ram_wdata=0, ram_wmask=0, misalign=0, captured/result registers=0.
REQ-021 Reset during BUSY SHALL abandon the access; ram_req SHALL be 0 in the cycle after the reset edge.
REQ-022 While rst=1, stall_req SHALL be 0 and wb_we SHALL be 0.

Structure
REQ-023 mem_op codes and `MemOpBus width SHALL live in the shared defines.v alongside `RegBus/`RegAddrBus.
REQ-024 Load lane-select/extension SHALL be one combinational sub-module load_align (inputs op, addr[1:0], rdata; output 32-bit value); the rest stays in mem_stage.

Verification
REQ-025 NONE op, mem_reg_waddr=5, mem_we=1, mem_reg_wdata=0x1234 -> same cycle wb_*=5/1/0x1234, stall_req=0, ram_req=0.
REQ-026 LB addr=0x103, ram_rdata=0x80FF_0000, ack after 2 BUSY cycles -> ram_addr=0x100 held both cycles; DONE wb_reg_wdata=0xFFFF_FF80; total 4 cycles of stall+done.
REQ-027 SH addr=0x22, sdata=0xABCD_5678 -> BUSY ram_wr=1, ram_wdata=0x5678_5678, ram_wmask=1100, ram_addr=0x20; DONE wb_we=captured mem_we.
REQ-028 LW addr=0x6 -> misalign=1 next cycle, ram_req never 1, stall_req=0, wb_we=0.
REQ-029 LHU addr=0x2 in BUSY, assert rst one cycle -> next cycle IDLE, ram_req=0, stall_req=0; stray ram_ack afterwards causes no DONE.
